// File: rtl/wr_arria10_reconfig_master.sv
// ---------------------------------------------------------------------------
// wr_arria10_reconfig_master
//
// Avalon-MM master for the Arria10 WR transceiver PHY dynamic-reconfiguration
// slave. It runs single-word read, write and read-modify-write commands from
// the WR core, honours waitrequest, aborts any access held longer than
// g_timeout cycles, and returns exactly one response per command.
//
// Optional feature (macro WR_A10_RECONFIG_VERIFY_EN): after every successful
// write (op 01 / op 10) the same address is read back. A readback mismatch
// returns err=1 with the readback value as data.
//
// Ports
//   clk_sys_i          PHY reconfig clock
//   rst_n_i            asynchronous active-low reset
//   cmd_valid_i/ready_o command handshake (one command outstanding)
//   cmd_op_i           00 read, 01 write, 10 read-modify-write, 11 illegal
//   cmd_addr_i         register address
//   cmd_data_i         write data
//   cmd_mask_i         RMW mask (1 = take cmd_data bit)
//   rsp_valid_o        one-cycle response strobe
//   rsp_data_o         read data, or final written word for write/RMW
//   rsp_err_o          timeout, illegal op or readback mismatch
//   avm_*              Avalon-MM master toward the PHY reconfig slave
// ---------------------------------------------------------------------------
module wr_arria10_reconfig_master #(
    parameter int g_addr_width = 10,
    parameter int g_timeout    = 1023
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [g_addr_width-1:0] cmd_addr_i,
    input  logic [31:0]             cmd_data_i,
    input  logic [31:0]             cmd_mask_i,
    output logic                    rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic [g_addr_width-1:0] avm_address_o,
    output logic                    avm_read_o,
    output logic                    avm_write_o,
    output logic [31:0]             avm_writedata_o,
    input  logic [31:0]             avm_readdata_i,
    input  logic                    avm_waitrequest_i
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
`ifdef WR_A10_RECONFIG_VERIFY_EN
    localparam logic [2:0] ST_VRD  = 3'd4;
`endif

    // Abort fires on the stalled cycle that would bring the count to g_timeout.
    localparam logic [15:0] TMO_LAST = 16'(g_timeout - 1);

    // Merge the current register word with the masked command data.
    function automatic logic [31:0] rmw_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_bits,
                                              input logic [31:0] mask);
        return (old_word & ~mask) | (new_bits & mask);
    endfunction

    logic [2:0]              state_r;
    logic [1:0]              op_r;
    logic [g_addr_width-1:0] addr_r;
    logic [31:0]             data_r;
    logic [31:0]             mask_r;
    logic [31:0]             word_r;
    logic [15:0]             tmo_cnt_r;
    logic                    cmd_ready_r;
    logic                    rsp_valid_r;
    logic [31:0]             rsp_data_r;
    logic                    rsp_err_r;
    logic                    avm_read_r;
    logic                    avm_write_r;

    logic                    tmo_hit_s;
    logic [31:0]             merged_s;

    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
    assign merged_s  = rmw_merge(avm_readdata_i, data_r, mask_r);

    assign cmd_ready_o     = cmd_ready_r;
    assign rsp_valid_o     = rsp_valid_r;
    assign rsp_data_o      = rsp_data_r;
    assign rsp_err_o       = rsp_err_r;
    assign avm_address_o   = addr_r;
    assign avm_read_o      = avm_read_r;
    assign avm_write_o     = avm_write_r;
    assign avm_writedata_o = word_r;

    // Command sequencer: accept, bus accesses with timeout, response strobe.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            addr_r      <= '0;
            data_r      <= 32'h0000_0000;
            mask_r      <= 32'h0000_0000;
            word_r      <= 32'h0000_0000;
            tmo_cnt_r   <= 16'd0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            avm_read_r  <= 1'b0;
            avm_write_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_r) begin
                        op_r        <= cmd_op_i;
                        addr_r      <= cmd_addr_i;
                        data_r      <= cmd_data_i;
                        mask_r      <= cmd_mask_i;
                        cmd_ready_r <= 1'b0;
                        tmo_cnt_r   <= 16'd0;
                        case (cmd_op_i)
                            OP_READ, OP_RMW: begin
                                state_r    <= ST_RD;
                                avm_read_r <= 1'b1;
                            end
                            OP_WRITE: begin
                                state_r     <= ST_WR;
                                word_r      <= cmd_data_i;
                                avm_write_r <= 1'b1;
                            end
                            default: begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b1;
                                rsp_data_r  <= 32'h0000_0000;
                            end
                        endcase
                    end
                end

                ST_RD: begin
                    if (!avm_waitrequest_i) begin
                        avm_read_r <= 1'b0;
                        if (op_r == OP_RMW) begin
                            // Write is raised one cycle later by ST_WR, leaving a bus gap.
                            state_r   <= ST_WR;
                            word_r    <= merged_s;
                            tmo_cnt_r <= 16'd0;
                        end else begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_data_r  <= avm_readdata_i;
                        end
                    end else if (tmo_hit_s) begin
                        avm_read_r  <= 1'b0;
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end

                ST_WR: begin
                    if (!avm_write_r) begin
                        // Idle gap cycle after the RMW read.
                        avm_write_r <= 1'b1;
                    end else if (!avm_waitrequest_i) begin
                        avm_write_r <= 1'b0;
`ifdef WR_A10_RECONFIG_VERIFY_EN
                        state_r   <= ST_VRD;
                        tmo_cnt_r <= 16'd0;
`else
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_data_r  <= word_r;
`endif
                    end else if (tmo_hit_s) begin
                        avm_write_r <= 1'b0;
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end

`ifdef WR_A10_RECONFIG_VERIFY_EN
                ST_VRD: begin
                    if (!avm_read_r) begin
                        // Idle gap cycle after the write.
                        avm_read_r <= 1'b1;
                    end else if (!avm_waitrequest_i) begin
                        avm_read_r  <= 1'b0;
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        if (avm_readdata_i != word_r) begin
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= avm_readdata_i;
                        end else begin
                            rsp_err_r  <= 1'b0;
                            rsp_data_r <= word_r;
                        end
                    end else if (tmo_hit_s) begin
                        avm_read_r  <= 1'b0;
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
`endif

                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    avm_read_r  <= 1'b0;
                    avm_write_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_arria10_reconfig_master.sv
// Self-checking bench for wr_arria10_reconfig_master: a reactive PHY slave
// model, a command-level reference model, and one compare process.
module tb_wr_arria10_reconfig_master;

    localparam int T = 16;
    localparam logic [9:0] RO_ADDR = 10'h3FF;   // PHY register that ignores writes, reads 0
    localparam int STUCK = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [9:0]  cmd_addr = 10'h000;
    logic [31:0] cmd_data = 32'h0;
    logic [31:0] cmd_mask = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [9:0]  avm_addr;
    logic        avm_rd;
    logic        avm_wr;
    logic [31:0] avm_wdata;
    logic [31:0] avm_rdata = 32'h0;
    logic        avm_wait = 1'b0;

    wr_arria10_reconfig_master #(.g_addr_width(10), .g_timeout(T)) dut (
        .clk_sys_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .avm_address_o(avm_addr), .avm_read_o(avm_rd), .avm_write_o(avm_wr),
        .avm_writedata_o(avm_wdata), .avm_readdata_i(avm_rdata),
        .avm_waitrequest_i(avm_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          n_rd;
        int          n_wr;
        bit          wdone;
        logic [31:0] wdata;
        int          acc;
        int          rd_base;
        int          wr_base;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] phy_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stall_cfg = 0;
    int          rd_starts = 0;
    int          wr_starts = 0;
    int          rsp_count = 0;
    int          last_hold = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_rsp_data = 32'h0;
    logic        last_rsp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [9:0] a);
        return (a == RO_ADDR) ? 32'h0 : ref_mem[a];
    endfunction

    // Reference model: response, latency and bus accesses of one command,
    // given that every access of the command is stalled s cycles.
    task automatic model_cmd(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                             input logic [31:0] m, input int s, output exp_t e);
        int t = 1;
        logic [31:0] w = d;
        e.data = 32'h0; e.err = 1'b0; e.n_rd = 0; e.n_wr = 0; e.wdone = 1'b0; e.wdata = 32'h0;
        e.acc = 0; e.rd_base = 0; e.wr_base = 0;
        if (op == 2'b11) begin
            e.err = 1'b1;
        end else if (op == 2'b00) begin
            e.n_rd = 1;
            if (s >= T) begin t += T; e.err = 1'b1; end
            else begin t += 1 + s; e.data = ref_rd(a); end
        end else begin
            if (op == 2'b10) begin
                e.n_rd = 1;
                if (s >= T) begin t += T; e.err = 1'b1; end
                else begin t += 2 + s; w = (ref_rd(a) & ~m) | (d & m); end
            end
            if (!e.err) begin
                e.n_wr = 1;
                if (s >= T) begin t += T; e.err = 1'b1; end
                else begin
                    t += 1 + s;
                    if (a != RO_ADDR) ref_mem[a] = w;
                    e.wdone = 1'b1; e.wdata = w; e.data = w;
`ifdef WR_A10_RECONFIG_VERIFY_EN
                    e.n_rd++;
                    t += 1;
                    if (s >= T) begin t += T; e.err = 1'b1; e.data = 32'h0; end
                    else begin
                        t += 1 + s;
                        if (ref_rd(a) != w) begin e.err = 1'b1; e.data = ref_rd(a); end
                    end
`endif
                end
            end
        end
        e.lat = t;
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // PHY slave model: waitrequest for stall_cfg cycles per access, data valid with waitrequest low.
    initial begin : phy
        int  stall_cnt;
        bit  prev_act;
        stall_cnt = 0;
        prev_act = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_act = 1'b0;
                avm_wait = 1'b0;
            end else begin
                if ((avm_rd || avm_wr) && !prev_act) stall_cnt = stall_cfg;
                avm_wait = (avm_rd || avm_wr) && (stall_cnt > 0);
                if (avm_wait) stall_cnt--;
                avm_rdata = (avm_addr == RO_ADDR) ? 32'h0 : phy_mem[avm_addr];
                if (avm_wr && !avm_wait && avm_addr != RO_ADDR) phy_mem[avm_addr] = avm_wdata;
                prev_act = (avm_rd || avm_wr) && avm_wait;
            end
        end
    end

    // Compare process: bus rules every active cycle, responses against the model queue.
    initial begin : cmp
        bit          p_act, p_wait, p_rd, act;
        logic [9:0]  p_addr;
        logic [31:0] p_wdata;
        int          cur_hold;
        exp_t        e;
        p_act = 1'b0; p_wait = 1'b0; p_rd = 1'b0; p_addr = 10'h0; p_wdata = 32'h0; cur_hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_act = 1'b0; p_wait = 1'b0;
            end else begin
                act = avm_rd || avm_wr;
                if (act) begin
                    check("rd_wr_exclusive", {31'd0, avm_rd & avm_wr}, 32'd0);
                    check("idle_gap", {31'd0, p_act & ~p_wait}, 32'd0);
                    if (p_act && p_wait) begin
                        check("addr_stable", {22'd0, avm_addr}, {22'd0, p_addr});
                        check("type_stable", {31'd0, avm_rd}, {31'd0, p_rd});
                        if (avm_wr) check("wdata_stable", avm_wdata, p_wdata);
                        cur_hold++;
                    end else begin
                        if (avm_rd) rd_starts++; else wr_starts++;
                        cur_hold = 1;
                    end
                    if (!avm_wait) begin
                        last_hold = cur_hold;
                        if (avm_wr) last_wdata = avm_wdata;
                    end
                end
                p_act = act; p_wait = avm_wait; p_rd = avm_rd; p_addr = avm_addr; p_wdata = avm_wdata;
                if (rsp_valid) begin
                    rsp_count++;
                    last_rsp_data = rsp_data;
                    last_rsp_err = rsp_err;
                    check("ready_low_in_resp", {31'd0, cmd_ready}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                        check("read_count", 32'(rd_starts - e.rd_base), 32'(e.n_rd));
                        check("write_count", 32'(wr_starts - e.wr_base), 32'(e.n_wr));
                        if (e.wdone) check("write_word", last_wdata, e.wdata);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                         input logic [31:0] m, input int s, input bit want_rsp);
        int   guard = 0;
        exp_t e;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        check("ready_wait", {31'd0, cmd_ready}, 32'd1);
        stall_cfg = s;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        if (want_rsp) begin
            model_cmd(op, a, d, m, s, e);
            e.acc = cyc; e.rd_base = rd_starts; e.wr_base = wr_starts;
            exp_q.push_back(e);
        end
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(exp_q.size() == 0 && cmd_ready) && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        check("cmd_complete", 32'(exp_q.size()), 32'd0);
    endtask

    logic [1:0]  tb_op   [0:5] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [9:0]  tb_addr [0:5] = '{10'h000, 10'h000, 10'h000, 10'h3FE, 10'h3FE, 10'h001};
    logic [31:0] tb_data [0:5] = '{32'hA5A5A5A5, 32'h0, 32'h0F0F0F0F, 32'h12345678, 32'h0, 32'h0};
    logic [31:0] tb_mask [0:5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    int          tb_stall[0:5] = '{2, 3, 1, 0, T - 1, T};

    initial begin
        int rc;
        for (int i = 0; i < 1024; i++) begin
            phy_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[i] = phy_mem[i];
        end
        phy_mem[10'h0A7] = 32'h1234_5678; ref_mem[10'h0A7] = 32'h1234_5678;
        phy_mem[10'h0B0] = 32'hFFFF_0000; ref_mem[10'h0B0] = 32'hFFFF_0000;

        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_bus", {20'd0, avm_addr, avm_rd, avm_wr}, 32'd0);
        check("reset_wdata", avm_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Plain read.
        issue(2'b00, 10'h0A7, 32'h0, 32'h0, 0, 1'b1);
        wait_idle();
        check("t1_read_data", last_rsp_data, 32'h1234_5678);
        check("t1_read_hold", 32'(last_hold), 32'd1);

        // RMW merge.
        issue(2'b10, 10'h0B0, 32'h0000_00A5, 32'h0000_00FF, 0, 1'b1);
        wait_idle();
        check("t2_rmw_data", last_rsp_data, 32'hFFFF_00A5);
        check("t2_rmw_wdata", last_wdata, 32'hFFFF_00A5);

        // Write stalled 5 cycles.
        issue(2'b01, 10'h0C4, 32'hDEAD_BEEF, 32'h0, 5, 1'b1);
        wait_idle();
        check("t3_hold_cycles", 32'(last_hold), 32'd6);
        check("t3_err", {31'd0, last_rsp_err}, 32'd0);

        // RMW read stuck -> timeout, no write.
        issue(2'b10, 10'h0B0, 32'h0000_0011, 32'h0000_00FF, STUCK, 1'b1);
        wait_idle();
        check("t4_timeout_err", {31'd0, last_rsp_err}, 32'd1);
        check("t4_timeout_data", last_rsp_data, 32'd0);
        check("t4_no_commit", phy_mem[10'h0B0], 32'hFFFF_00A5);

        // Illegal op, then back-to-back read.
        issue(2'b11, 10'h0A7, 32'h0, 32'h0, 0, 1'b1);
        issue(2'b00, 10'h0A7, 32'h0, 32'h0, 0, 1'b1);
        wait_idle();
        check("t5_read_after_illegal", last_rsp_data, 32'h1234_5678);

        // Directed table: boundaries on address and on the timeout limit.
        for (int i = 0; i < 6; i++) begin
            issue(tb_op[i], tb_addr[i], tb_data[i], tb_mask[i], tb_stall[i], 1'b1);
            wait_idle();
        end
        check("tbl_timeout_exact", {31'd0, last_rsp_err}, 32'd1);

        // Reset in the middle of a stalled write.
        issue(2'b01, 10'h0D0, 32'h1111_1111, 32'h0, STUCK, 1'b0);
        repeat (2) begin @(negedge clk); #1; end
        check("t6_write_held", {31'd0, avm_wr}, 32'd1);
        rc = rsp_count;
        rst_n = 1'b0;
        #1;
        check("t6_write_drop", {31'd0, avm_wr}, 32'd0);
        repeat (2) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); #1; end
        check("t6_no_rsp", 32'(rsp_count), 32'(rc));
        check("t6_ready_after", {31'd0, cmd_ready}, 32'd1);

        // Write to a register that ignores writes.
        issue(2'b01, RO_ADDR, 32'h0000_0005, 32'h0, 0, 1'b1);
        wait_idle();
`ifdef WR_A10_RECONFIG_VERIFY_EN
        check("t6_verify_err", {31'd0, last_rsp_err}, 32'd1);
        check("t6_verify_data", last_rsp_data, 32'h0);
`else
        check("t6_ro_err", {31'd0, last_rsp_err}, 32'd0);
        check("t6_ro_data", last_rsp_data, 32'h5);
`endif

        repeat (3) begin @(negedge clk); #1; end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
